eth_rx_buf_writer: RTL

ETH_RX_BUF_WRITER -- requirements
Module: eth_rx_buf_writer

---
 rtl/eth_rx_buf_writer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_buf_writer.sv
// Write-side controller for a dual-port Ethernet receive frame RAM.
// Define ETH_RX_BUF_STATS_EN to build the saturating dropped-frame counter.
module eth_rx_buf_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MIN_LEN    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_last,
  input  logic                  rx_error,
  input  logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_wraddress,
  output logic                  ram_wren,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [ADDR_WIDTH-1:0] desc_addr,
  output logic [15:0]           desc_len,
  output logic [15:0]           drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    DROP   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [15:0]           MIN_LEN_W = 16'(MIN_LEN);

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   wr_ptr_r, wr_ptr_s;
  logic [ADDR_WIDTH-1:0]   start_r, start_s;
  logic [15:0]             len_r, len_s;
  logic [ADDR_WIDTH-1:0]   free_s;
  logic [ADDR_WIDTH-1:0]   base_start_s;
  logic [15:0]             base_len_s;
  logic [15:0]             next_len_s;
  logic                    first_s;
  logic                    desc_busy_s;
  logic                    wr_en_s;

  logic                    ram_wren_r;
  logic [DATA_WIDTH-1:0]   ram_data_r;
  logic [ADDR_WIDTH-1:0]   ram_wraddress_r;
  logic                    desc_valid_r;
  logic [ADDR_WIDTH-1:0]   desc_addr_r;
  logic [15:0]             desc_len_r;

  // One slot is always kept empty so a full buffer never looks empty to the reader.
  assign free_s       = rd_ptr - wr_ptr_r - ADDR_ONE;
  // A frame may begin in COMMIT; the descriptor being published then counts as occupied.
  assign first_s      = (state_r == IDLE) || (state_r == COMMIT);
  assign base_start_s = first_s ? wr_ptr_r : start_r;
  assign base_len_s   = first_s ? 16'd0 : len_r;
  assign next_len_s   = (base_len_s == 16'hFFFF) ? base_len_s : base_len_s + 16'd1;
  assign desc_busy_s  = (desc_valid_r && !desc_ready) || (state_r == COMMIT);

  // Next-state, write-pointer and frame bookkeeping
  always_comb begin
    state_s  = state_r;
    wr_ptr_s = wr_ptr_r;
    start_s  = start_r;
    len_s    = len_r;
    wr_en_s  = 1'b0;
    case (state_r)
      IDLE, COMMIT, WRITE: begin
        if (rx_valid) begin
          start_s = base_start_s;
          if (free_s == ADDR_ZERO) begin
            wr_ptr_s = base_start_s;
            state_s  = rx_last ? IDLE : DROP;
          end else begin
            wr_en_s  = 1'b1;
            wr_ptr_s = wr_ptr_r + ADDR_ONE;
            len_s    = next_len_s;
            if (rx_last) begin
              if (rx_error || (next_len_s < MIN_LEN_W) || desc_busy_s) begin
                wr_ptr_s = base_start_s;
                state_s  = IDLE;
              end else begin
                state_s  = COMMIT;
              end
            end else begin
              state_s = WRITE;
            end
          end
        end else if (state_r == COMMIT) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      DROP: begin
        if (rx_valid && rx_last) begin
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      wr_ptr_r <= ADDR_ZERO;
      start_r  <= ADDR_ZERO;
      len_r    <= 16'd0;
    end else begin
      state_r  <= state_s;
      wr_ptr_r <= wr_ptr_s;
      start_r  <= start_s;
      len_r    <= len_s;
    end
  end

  // RAM write port, one cycle behind the accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wren_r      <= 1'b0;
      ram_data_r      <= {DATA_WIDTH{1'b0}};
      ram_wraddress_r <= ADDR_ZERO;
    end else begin
      ram_wren_r <= wr_en_s;
      if (wr_en_s) begin
        ram_data_r      <= rx_data;
        ram_wraddress_r <= wr_ptr_r;
      end
    end
  end

  // Descriptor holds until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_valid_r <= 1'b0;
      desc_addr_r  <= ADDR_ZERO;
      desc_len_r   <= 16'd0;
    end else if (state_r == COMMIT) begin
      desc_valid_r <= 1'b1;
      desc_addr_r  <= start_r;
      desc_len_r   <= len_r;
    end else if (desc_valid_r && desc_ready) begin
      desc_valid_r <= 1'b0;
    end
  end

  assign ram_wren      = ram_wren_r;
  assign ram_data      = ram_data_r;
  assign ram_wraddress = ram_wraddress_r;
  assign desc_valid    = desc_valid_r;
  assign desc_addr     = desc_addr_r;
  assign desc_len      = desc_len_r;

`ifdef ETH_RX_BUF_STATS_EN
  logic [15:0] drop_cnt_r;
  logic        drop_ev_s;

  // Leaving a live frame for IDLE or DROP on a word is exactly a discard.
  assign drop_ev_s = rx_valid && (state_r != DROP) &&
                     ((state_s == IDLE) || (state_s == DROP));

  // Saturating dropped-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 16'd0;
    end else if (drop_ev_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule
